writeback_queue: RTL and testbench

Buffers register-file writeback requests in a small in-order FIFO and drains them, one per cycle, onto the register file's single write port (`Dc`, `rd`, `wenable`). It sits directly upstream of the 32×32 register file. It absorbs cycles in which that port is unavailable (`rf_stall`). It also forwards not-yet-written data to the read operands `rs1`/`rs2`, so consumers never read a stale register.

---
 rtl/writeback_queue.sv | 112 +++++++++++
 tb/tb_writeback_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order writeback FIFO feeding the register-file write port
// Drains one entry per cycle unless rf_stall, and forwards pending data to rs1/rs2.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  input  logic [31:0]   wb_data,
  output logic          wb_ready,
  input  logic          rf_stall,
  output logic [31:0]   Dc,
  output logic [4:0]    rd,
  output logic          wenable,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [31:0]   fwd_a_data,
  output logic [31:0]   fwd_b_data,
  output logic [CW-1:0] pending_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty    = (count_q == '0);
  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign wb_ready = (count_q < CW'(DEPTH));
  assign wenable  = !empty && !rf_stall;
  assign push     = wb_valid && wb_ready;
  assign pop      = wenable;

  assign rd            = empty ? 5'd0  : rd_q[head_q];
  assign Dc            = empty ? 32'd0 : data_q[head_q];
  assign pending_count = count_q;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid bits and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_q[tail_q]   <= wb_rd;
      data_q[tail_q] <= wb_data;
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = 32'd0;
    fwd_b_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (rd_q[idx] == rs1)) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = data_q[idx];
      end
      if (valid_q[idx] && (rd_q[idx] == rs2)) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed scoreboard bench for writeback_queue
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic          CLK = 1'b0;
  logic          reset;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          wb_ready;
  logic          rf_stall;
  logic [31:0]   Dc;
  logic [4:0]    rd;
  logic          wenable;
  logic [4:0]    rs1, rs2;
  logic          fwd_a_hit, fwd_b_hit;
  logic [31:0]   fwd_a_data, fwd_b_data;
  logic [CW-1:0] pending_count;

  ent_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ready(wb_ready), .rf_stall(rf_stall), .Dc(Dc), .rd(rd), .wenable(wenable),
    .rs1(rs1), .rs2(rs2), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data), .pending_count(pending_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs at the negedge against the model, then advance past the posedge.
  task automatic cycle();
    logic        exp_we, can_push;
    logic        ha, hb;
    logic [31:0] da, db;
    ent_t        e;
    @(negedge CLK);
    can_push = reset && (sb.size() < DEPTH);
    exp_we   = reset && (sb.size() != 0) && !rf_stall;
    check("wenable", 32'(wenable), 32'(exp_we));
    check("wb_ready", 32'(wb_ready), 32'(sb.size() < DEPTH));
    check("pending_count", 32'(pending_count), 32'(sb.size()));
    ha = 1'b0; hb = 1'b0; da = 32'd0; db = 32'd0;
    foreach (sb[i]) begin
      if (sb[i].rd == rs1) begin ha = 1'b1; da = sb[i].data; end
      if (sb[i].rd == rs2) begin hb = 1'b1; db = sb[i].data; end
    end
    check("fwd_a_hit", 32'(fwd_a_hit), 32'(ha));
    check("fwd_a_data", fwd_a_data, da);
    check("fwd_b_hit", 32'(fwd_b_hit), 32'(hb));
    check("fwd_b_data", fwd_b_data, db);
    if (sb.size() == 0) begin
      check("rd_idle", 32'(rd), 32'd0);
      check("Dc_idle", Dc, 32'd0);
    end else if (exp_we) begin
      e = sb.pop_front();
      check("rd_write", 32'(rd), 32'(e.rd));
      check("Dc_write", Dc, e.data);
    end
    if (wb_valid && can_push) sb.push_back('{rd: wb_rd, data: wb_data});
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
    cycle();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    rf_stall = 1'b0; rs1 = '0; rs2 = '0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      rf_stall = 1'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      cycle();
    end
    wb_valid = 1'b0; rf_stall = 1'b0; rs1 = 5'd31; rs2 = 5'd30;
    reset = 1'b1;

    // Single write
    push(5'd5, 32'hDEADBEEF);
    check("single_wenable_n1", 32'(wenable), 32'd1);
    check("single_rd_n1", 32'(rd), 32'd5);
    cycle();
    cycle();
    check("single_count_n2", 32'(pending_count), 32'd0);

    // Fill under stall, overflow attempt, then drain in order
    rf_stall = 1'b1;
    push(5'd1, 32'h11);
    push(5'd2, 32'h22);
    push(5'd3, 32'h33);
    push(5'd4, 32'h44);
    check("full_ready", 32'(wb_ready), 32'd0);
    check("full_count", 32'(pending_count), 32'd4);
    push(5'd9, 32'h99);
    check("overflow_ignored", 32'(pending_count), 32'd4);
    rf_stall = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Steady push/pop with pointer wrap
    rf_stall = 1'b1;
    push(5'd10, 32'h1000);
    push(5'd11, 32'h1001);
    rf_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(12 + i); wb_data = $urandom;
      cycle();
      check("steady_count", 32'(pending_count), 32'd2);
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Forwarding: youngest wins, miss gives zero, head-in-write still hits
    rf_stall = 1'b1;
    rs1 = 5'd7; rs2 = 5'd3;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    push(5'd3, 32'hC);
    cycle();
    check("fwd_a_youngest", fwd_a_data, 32'hB);
    check("fwd_b_data_c", fwd_b_data, 32'hC);
    rs1 = 5'd8;
    cycle();
    rs1 = 5'd7;
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-operation discards pending writes
    rf_stall = 1'b1;
    push(5'd20, 32'h2020);
    push(5'd21, 32'h2121);
    push(5'd22, 32'h2222);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    sb.delete();
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("post_reset_count", 32'(pending_count), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
